// File: rtl/adaptive_threshold_pkg.sv
// adaptive_threshold_pkg
// Shared definitions for the adaptive-thresholding frame sequencer:
//   - seqState_t : sequencer state encoding (3 bits, IDLE..ERROR)
//   - LED_*      : one-hot status patterns shown on oLed[4:0]
//   - DEFAULT_*  : default image / offset widths
//   - stateLed() : maps a state to its one-hot LED pattern
package adaptive_threshold_pkg;

  localparam int STATE_BITS = 3;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE  = 3'd0,
    BOX   = 3'd1,
    THR   = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } seqState_t;

  localparam logic [4:0] LED_IDLE  = 5'b00001;
  localparam logic [4:0] LED_BOX   = 5'b00010;
  localparam logic [4:0] LED_THR   = 5'b00100;
  localparam logic [4:0] LED_DONE  = 5'b01000;
  localparam logic [4:0] LED_ERROR = 5'b10000;

  localparam int DEFAULT_WIDTH_BITS  = 8;
  localparam int DEFAULT_HEIGHT_BITS = 8;
  localparam int DEFAULT_C_BITS      = 5;

  function automatic logic [4:0] stateLed(input seqState_t s);
    case (s)
      IDLE:    stateLed = LED_IDLE;
      BOX:     stateLed = LED_BOX;
      THR:     stateLed = LED_THR;
      DONE:    stateLed = LED_DONE;
      ERROR:   stateLed = LED_ERROR;
      default: stateLed = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/adaptive_threshold_sequencer_stage_watchdog.sv
// stage_watchdog
// Free-running per-stage cycle counter used to detect a hung stage.
// Ports:
//   clock      rising-edge clock
//   not_reset  synchronous active-low reset (count -> 0)
//   clear      zero the count (wins over enable)
//   enable     advance the count by one
//   terminal   high while the count is all ones
module stage_watchdog #(
  parameter int TIMEOUT_BITS = 20
) (
  input  logic clock,
  input  logic not_reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [TIMEOUT_BITS-1:0] count;

  always_ff @(posedge clock) begin
    if (!not_reset)  count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign terminal = &count;

endmodule

// File: rtl/adaptive_threshold_sequencer.sv
// adaptive_threshold_sequencer
// Runs one box-filter pass followed by one threshold pass per frame, muxes
// the shared image-memory address between the two stages, latches the
// per-frame threshold offset and invert mode, and counts completed frames.
// Ports:
//   clock, not_reset            clock and synchronous active-low reset
//   iStart/iContinuous/iAbort   frame control (levels)
//   iC, iInvert -> oC, oInvert  per-frame config, latched at frame start
//   oBoxStart, iBoxFinished     box-filter handshake
//   oThrStart, iThrFinished     threshold-stage handshake
//   iBox*/iThr* -> oImage*      image address mux (THR selects threshold)
//   oBusy, oDone, oError        status (busy in BOX/THR, done pulse, error)
//   oState, oFrameCount, oLed   encoded state, frame count, LED status
module adaptive_threshold_sequencer
  import adaptive_threshold_pkg::*;
#(
  parameter int WIDTH_BITS     = DEFAULT_WIDTH_BITS,
  parameter int HEIGHT_BITS    = DEFAULT_HEIGHT_BITS,
  parameter int C_BITS         = DEFAULT_C_BITS,
  parameter int TIMEOUT_BITS   = 20,
  parameter int FRAME_CNT_BITS = 16
) (
  input  logic                      clock,
  input  logic                      not_reset,
  input  logic                      iStart,
  input  logic                      iContinuous,
  input  logic                      iAbort,
  input  logic [C_BITS-1:0]         iC,
  input  logic                      iInvert,
  output logic [C_BITS-1:0]         oC,
  output logic                      oInvert,
  output logic                      oBoxStart,
  input  logic                      iBoxFinished,
  output logic                      oThrStart,
  input  logic                      iThrFinished,
  input  logic [WIDTH_BITS-1:0]     iBoxCol,
  input  logic [HEIGHT_BITS-1:0]    iBoxRow,
  input  logic [WIDTH_BITS-1:0]     iThrCol,
  input  logic [HEIGHT_BITS-1:0]    iThrRow,
  output logic [WIDTH_BITS-1:0]     oImageCol,
  output logic [HEIGHT_BITS-1:0]    oImageRow,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oError,
  output logic [2:0]                oState,
  output logic [FRAME_CNT_BITS-1:0] oFrameCount,
  output logic [9:0]                oLed
);

  seqState_t                 state, nextState;
  logic [C_BITS-1:0]         cReg, cNext;
  logic                      invReg, invNext;
  logic                      boxStartReg, boxStartNext;
  logic                      thrStartReg, thrStartNext;
  logic [FRAME_CNT_BITS-1:0] frameCount, frameCountNext;
  logic                      startFrame;
  logic                      wdTerminal;
  logic                      wdClear;

  // Any state change restarts the watchdog, so each stage gets a full
  // timeout window from its first cycle.
  assign wdClear = (nextState != state);

  stage_watchdog #(
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) uWatchdog (
    .clock    (clock),
    .not_reset(not_reset),
    .clear    (wdClear),
    .enable   (oBusy),
    .terminal (wdTerminal)
  );

  always_ff @(posedge clock) begin
    if (!not_reset) begin
      state       <= IDLE;
      cReg        <= '0;
      invReg      <= 1'b0;
      boxStartReg <= 1'b0;
      thrStartReg <= 1'b0;
      frameCount  <= '0;
    end else begin
      state       <= nextState;
      cReg        <= cNext;
      invReg      <= invNext;
      boxStartReg <= boxStartNext;
      thrStartReg <= thrStartNext;
      frameCount  <= frameCountNext;
    end
  end

  // Priority inside a busy stage: abort, then finished, then watchdog.
  always_comb begin
    nextState      = state;
    cNext          = cReg;
    invNext        = invReg;
    boxStartNext   = 1'b0;
    thrStartNext   = 1'b0;
    frameCountNext = frameCount;
    startFrame     = 1'b0;
    case (state)
      IDLE, ERROR: startFrame = iStart;
      BOX: begin
        if (iAbort) nextState = IDLE;
        else if (iBoxFinished) begin
          nextState    = THR;
          thrStartNext = 1'b1;
        end else if (wdTerminal) nextState = ERROR;
      end
      THR: begin
        if (iAbort) nextState = IDLE;
        else if (iThrFinished) begin
          nextState      = DONE;
          frameCountNext = frameCount + 1'b1;
        end else if (wdTerminal) nextState = ERROR;
      end
      DONE: begin
        if (iContinuous && !iAbort) startFrame = 1'b1;
        else nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Shared frame-start path for IDLE, ERROR and continuous DONE.
    if (startFrame) begin
      nextState    = BOX;
      boxStartNext = 1'b1;
      cNext        = iC;
      invNext      = iInvert;
    end
  end

  assign oC          = cReg;
  assign oInvert     = invReg;
  assign oBoxStart   = boxStartReg;
  assign oThrStart   = thrStartReg;
  assign oFrameCount = frameCount;
  assign oState      = state;
  assign oBusy       = (state == BOX) || (state == THR);
  assign oDone       = (state == DONE);
  // ERROR is only left through a start, so the flag is sticky by construction.
  assign oError      = (state == ERROR);
  assign oImageCol   = (state == THR) ? iThrCol : iBoxCol;
  assign oImageRow   = (state == THR) ? iThrRow : iBoxRow;
  assign oLed        = {5'(cReg), stateLed(state)};

endmodule

// File: tb/tb_adaptive_threshold_sequencer.sv
module tb_adaptive_threshold_sequencer;
  localparam int WB = 8, HB = 8, CB = 5, TB = 4, FB = 2;
  localparam int S_IDLE = 0, S_BOX = 1, S_THR = 2, S_DONE = 3, S_ERR = 4;
  localparam int TMAX = (1 << TB) - 1;

  logic clock = 1'b0, not_reset = 1'b0;
  logic iStart = 1'b0, iContinuous = 1'b0, iAbort = 1'b0, iInvert = 1'b0;
  logic iBoxFinished = 1'b0, iThrFinished = 1'b0;
  logic [CB-1:0] iC = '0;
  logic [WB-1:0] iBoxCol = '0, iThrCol = '0;
  logic [HB-1:0] iBoxRow = '0, iThrRow = '0;
  logic [CB-1:0] oC;
  logic oInvert, oBoxStart, oThrStart, oBusy, oDone, oError;
  logic [WB-1:0] oImageCol;
  logic [HB-1:0] oImageRow;
  logic [2:0] oState;
  logic [FB-1:0] oFrameCount;
  logic [9:0] oLed;

  always #5 clock = ~clock;

  adaptive_threshold_sequencer #(
    .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .C_BITS(CB),
    .TIMEOUT_BITS(TB), .FRAME_CNT_BITS(FB)
  ) dut (
    .clock(clock), .not_reset(not_reset), .iStart(iStart),
    .iContinuous(iContinuous), .iAbort(iAbort), .iC(iC), .iInvert(iInvert),
    .oC(oC), .oInvert(oInvert), .oBoxStart(oBoxStart),
    .iBoxFinished(iBoxFinished), .oThrStart(oThrStart),
    .iThrFinished(iThrFinished), .iBoxCol(iBoxCol), .iBoxRow(iBoxRow),
    .iThrCol(iThrCol), .iThrRow(iThrRow), .oImageCol(oImageCol),
    .oImageRow(oImageRow), .oBusy(oBusy), .oDone(oDone), .oError(oError),
    .oState(oState), .oFrameCount(oFrameCount), .oLed(oLed)
  );

  int errors = 0, checks = 0;
  int nBox = 0, nThr = 0, nDone = 0, nIdle = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
    nBox  += int'(oBoxStart);
    nThr  += int'(oThrStart);
    nDone += int'(oDone);
    if (oState == 3'd0) nIdle++;
  endtask

  task automatic clearInputs();
    iStart = 0; iContinuous = 0; iAbort = 0; iInvert = 0;
    iBoxFinished = 0; iThrFinished = 0; iC = '0;
  endtask

  task automatic doReset();
    clearInputs();
    not_reset = 0; tick(); not_reset = 1;
  endtask

  // Table vectors: one row per clock edge.
  typedef struct packed {
    logic start, bf, tf, ab, cont;
    logic [4:0] c;
    logic inv;
    logic [2:0] st;
    logic bs, ts, dn;
    logic [1:0] cnt;
    logic [4:0] expC;
    logic expInv;
  } vec_t;
  vec_t tv[17];

  // Behavioural reference: phase of the frame plus cycles spent in the stage.
  int mPhase = S_IDLE, mAge = 0, mCount = 0;
  logic [4:0] mC = '0;
  logic mInv = 1'b0, mBs = 1'b0, mTs = 1'b0;

  task automatic modelStep();
    bit go;
    go = 0; mBs = 0; mTs = 0;
    if (!not_reset) begin
      mPhase = S_IDLE; mAge = 0; mCount = 0; mC = '0; mInv = 0;
    end else begin
      if (mPhase == S_IDLE || mPhase == S_ERR) go = iStart;
      else if (mPhase == S_BOX || mPhase == S_THR) begin
        if (iAbort) mPhase = S_IDLE;
        else if (mPhase == S_BOX && iBoxFinished) begin mPhase = S_THR; mTs = 1; mAge = 0; end
        else if (mPhase == S_THR && iThrFinished) begin mPhase = S_DONE; mCount = (mCount + 1) % (1 << FB); end
        else if (mAge == TMAX) mPhase = S_ERR;
        else mAge++;
      end else begin
        if (iContinuous && !iAbort) go = 1;
        else mPhase = S_IDLE;
      end
      if (go) begin mPhase = S_BOX; mBs = 1; mAge = 0; mC = iC; mInv = iInvert; end
    end
  endtask

  initial begin
    logic [4:0] cv[3];
    int errCycles;
    cv[0] = 5'd3; cv[1] = 5'd10; cv[2] = 5'd21;

    // Reset state
    doReset();
    chk("rst_state", oState, S_IDLE);
    chk("rst_led", oLed, 10'b00000_00001);
    chk("rst_flags", {oC, oInvert, oBoxStart, oThrStart, oDone, oError, oBusy}, 0);
    chk("rst_count", oFrameCount, 0);

    // Normal frame with address mux
    iBoxCol = 8'h11; iThrCol = 8'h22; iBoxRow = 8'h33; iThrRow = 8'h44; #1;
    chk("mux_idle", {oImageCol, oImageRow}, 16'h1133);
    nBox = 0; nThr = 0; nDone = 0;
    iC = 5'd12; iStart = 1; tick(); iStart = 0;
    chk("nf_box_state", oState, S_BOX);
    chk("nf_c", oC, 12);
    chk("mux_box", {oImageCol, oImageRow}, 16'h1133);
    repeat (10) tick();
    iBoxFinished = 1; tick(); iBoxFinished = 0;
    chk("nf_thr_state", oState, S_THR);
    chk("mux_thr", {oImageCol, oImageRow}, 16'h2244);
    repeat (10) tick();
    iThrFinished = 1; tick(); iThrFinished = 0;
    chk("nf_done_state", oState, S_DONE);
    chk("nf_done_led", oLed, 10'b01100_01000);
    chk("nf_count", oFrameCount, 1);
    chk("mux_done", {oImageCol, oImageRow}, 16'h1133);
    tick();
    chk("nf_idle_led", oLed, 10'b01100_00001);
    chk("nf_pulses", {8'(nBox), 8'(nThr), 8'(nDone)}, 24'h010101);

    // Reset in the middle of BOX
    iC = 5'd12; iInvert = 1; iStart = 1; tick(); iStart = 0;
    chk("rm_inv", oInvert, 1);
    iBoxFinished = 1; not_reset = 0; tick(); not_reset = 1; iBoxFinished = 0;
    chk("rm_state", oState, S_IDLE);
    chk("rm_flags", {oC, oInvert, oBoxStart, oThrStart, oDone, oError, oBusy}, 0);
    chk("rm_count", oFrameCount, 0);
    chk("rm_led", oLed, 10'b00000_00001);

    // Table-driven vectors
    doReset();
    tv[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd7, 1'b1, 3'd1,1'b1,1'b0,1'b0,2'd0,5'd7, 1'b1};
    tv[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,5'd31,1'b0, 3'd1,1'b0,1'b0,1'b0,2'd0,5'd7, 1'b1};
    tv[2]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,5'd30,1'b0, 3'd0,1'b0,1'b0,1'b0,2'd0,5'd7, 1'b1};
    tv[3]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,5'd29,1'b0, 3'd0,1'b0,1'b0,1'b0,2'd0,5'd7, 1'b1};
    tv[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd9, 1'b0, 3'd1,1'b1,1'b0,1'b0,2'd0,5'd9, 1'b0};
    tv[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,5'd28,1'b1, 3'd1,1'b0,1'b0,1'b0,2'd0,5'd9, 1'b0};
    tv[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,5'd27,1'b1, 3'd2,1'b0,1'b1,1'b0,2'd0,5'd9, 1'b0};
    tv[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,5'd26,1'b1, 3'd2,1'b0,1'b0,1'b0,2'd0,5'd9, 1'b0};
    tv[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,5'd25,1'b1, 3'd0,1'b0,1'b0,1'b0,2'd0,5'd9, 1'b0};
    tv[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd20,1'b1, 3'd1,1'b1,1'b0,1'b0,2'd0,5'd20,1'b1};
    tv[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,5'd19,1'b0, 3'd2,1'b0,1'b1,1'b0,2'd0,5'd20,1'b1};
    tv[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,5'd18,1'b0, 3'd3,1'b0,1'b0,1'b1,2'd1,5'd20,1'b1};
    tv[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd17,1'b0, 3'd0,1'b0,1'b0,1'b0,2'd1,5'd20,1'b1};
    tv[13] = '{1'b1,1'b0,1'b0,1'b0,1'b1,5'd16,1'b0, 3'd1,1'b1,1'b0,1'b0,2'd1,5'd16,1'b0};
    tv[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,5'd15,1'b1, 3'd2,1'b0,1'b1,1'b0,2'd1,5'd16,1'b0};
    tv[15] = '{1'b0,1'b0,1'b1,1'b0,1'b1,5'd14,1'b1, 3'd3,1'b0,1'b0,1'b1,2'd2,5'd16,1'b0};
    tv[16] = '{1'b0,1'b0,1'b0,1'b1,1'b1,5'd13,1'b1, 3'd0,1'b0,1'b0,1'b0,2'd2,5'd16,1'b0};
    for (int i = 0; i < 17; i++) begin
      iStart = tv[i].start; iBoxFinished = tv[i].bf; iThrFinished = tv[i].tf;
      iAbort = tv[i].ab; iContinuous = tv[i].cont; iC = tv[i].c; iInvert = tv[i].inv;
      tick();
      chk($sformatf("tv%0d_state", i), oState, tv[i].st);
      chk($sformatf("tv%0d_pulses", i), {oBoxStart, oThrStart, oDone}, {tv[i].bs, tv[i].ts, tv[i].dn});
      chk($sformatf("tv%0d_count", i), oFrameCount, tv[i].cnt);
      chk($sformatf("tv%0d_cfg", i), {oC, oInvert}, {tv[i].expC, tv[i].expInv});
    end
    clearInputs();

    // Continuous mode over three frames, then a fourth frame wraps the count
    doReset();
    nDone = 0;
    iContinuous = 1; iC = cv[0]; iStart = 1; tick(); iStart = 0;
    nIdle = 0;
    for (int f = 0; f < 3; f++) begin
      chk($sformatf("cont%0d_box", f), {oState, oBoxStart}, {3'd1, 1'b1});
      chk($sformatf("cont%0d_c", f), oC, cv[f]);
      iBoxFinished = 1; tick(); iBoxFinished = 0;
      iThrFinished = 1; tick(); iThrFinished = 0;
      chk($sformatf("cont%0d_done", f), oDone, 1);
      if (f < 2) begin iC = cv[f+1]; tick(); end
    end
    chk("cont_count", oFrameCount, 3);
    chk("cont_ndone", nDone, 3);
    chk("cont_no_idle", nIdle, 0);
    iContinuous = 0; tick();
    chk("cont_end_idle", oState, S_IDLE);
    iStart = 1; tick(); iStart = 0;
    iBoxFinished = 1; tick(); iBoxFinished = 0;
    iThrFinished = 1; tick(); iThrFinished = 0;
    chk("wrap_count", {oDone, 2'(oFrameCount)}, {1'b1, 2'd0});
    tick();

    // Watchdog
    doReset();
    iStart = 1; tick(); iStart = 0;
    repeat (15) tick();
    chk("wd_box_before", oState, S_BOX);
    tick();
    chk("wd_error", {oState, oError}, {3'd4, 1'b1});
    errCycles = 0;
    repeat (20) begin tick(); if (oError && oState == 3'd4) errCycles++; end
    chk("wd_sticky", errCycles, 20);
    iStart = 1; tick(); iStart = 0;
    chk("wd_restart", {oState, oError, oBoxStart}, {3'd1, 1'b0, 1'b1});
    repeat (15) tick();
    iBoxFinished = 1; tick(); iBoxFinished = 0;
    chk("wd_fin_wins", {oState, oThrStart}, {3'd2, 1'b1});
    repeat (15) tick();
    chk("wd_thr_before", oState, S_THR);
    tick();
    chk("wd_thr_error", {oState, oError}, {3'd4, 1'b1});
    iStart = 1; tick(); iStart = 0;
    repeat (15) tick();
    iAbort = 1; tick(); iAbort = 0;
    chk("wd_abort_wins", {oState, oError}, {3'd0, 1'b0});

    // Randomised run against the reference model
    for (int n = 0; n < 3000; n++) begin
      not_reset = (n == 0) ? 1'b0 : ($urandom_range(199) != 0);
      iStart = ($urandom_range(3) == 0);
      iBoxFinished = ($urandom_range(7) == 0);
      iThrFinished = ($urandom_range(7) == 0);
      iAbort = ($urandom_range(31) == 0);
      iContinuous = $urandom_range(1);
      iC = 5'($urandom); iInvert = $urandom_range(1);
      iBoxCol = 8'($urandom); iThrCol = 8'($urandom);
      iBoxRow = 8'($urandom); iThrRow = 8'($urandom);
      #1;
      if (n > 0)
        chk("rnd_addr", {oImageCol, oImageRow},
            (mPhase == S_THR) ? {iThrCol, iThrRow} : {iBoxCol, iBoxRow});
      modelStep();
      tick();
      chk("rnd_state", oState, mPhase);
      chk("rnd_flags", {oBoxStart, oThrStart, oDone, oError, oBusy},
          {mBs, mTs, mPhase == S_DONE, mPhase == S_ERR, (mPhase == S_BOX || mPhase == S_THR)});
      chk("rnd_cfg", {oC, oInvert}, {mC, mInv});
      chk("rnd_count", oFrameCount, mCount);
      chk("rnd_led", oLed, {mC, 5'(1 << mPhase)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adaptive_threshold_sequencer.md
Name: adaptive_threshold_sequencer

Overview:
Parametrised frame sequencer for the adaptive-thresholding datapath. It runs one box-filter pass and then one threshold pass per frame, and arbitrates the shared image-memory address between the two stages. It latches the per-frame threshold offset C and the invert mode, and counts completed frames. Compared with the fixed single-shot controller, it adds a start/busy/done handshake, continuous re-run mode, abort, a per-stage watchdog with a sticky error state, and generic image dimensions.

Parameters:
WIDTH_BITS, 8, column address width (image width = 2**WIDTH_BITS)
HEIGHT_BITS, 8, row address width (image height = 2**HEIGHT_BITS)
C_BITS, 5, width of threshold offset C
TIMEOUT_BITS, 20, width of per-stage watchdog counter
FRAME_CNT_BITS, 16, width of completed-frame counter

Ports:
clock  in  1  system clock; all logic on rising edge
not_reset  in  1  synchronous, active-low reset
iStart  in  1  level; sampled in IDLE or ERROR to begin a frame
iContinuous  in  1  level; when 1, DONE chains directly into the next frame
iAbort  in  1  level; abandons the frame in progress
iC  in  C_BITS  threshold offset, latched at frame start
iInvert  in  1  output-polarity mode, latched at frame start
oC  out  C_BITS  latched C for the threshold stage
oInvert  out  1  latched invert mode
oBoxStart  out  1  one-cycle start pulse to box filter
iBoxFinished  in  1  box filter completion (level or pulse)
oThrStart  out  1  one-cycle start pulse to threshold stage
iThrFinished  in  1  threshold stage completion
iBoxCol / iBoxRow  in  WIDTH_BITS / HEIGHT_BITS  box-filter image address
iThrCol / iThrRow  in  WIDTH_BITS / HEIGHT_BITS  threshold image address
oImageCol / oImageRow  out  WIDTH_BITS / HEIGHT_BITS  muxed image-memory address
oBusy  out  1  high in BOX and THR
oDone  out  1  one-cycle pulse on frame completion
oError  out  1  sticky watchdog error flag
oState  out  3  encoded state
oFrameCount  out  FRAME_CNT_BITS  completed frames, wraps to 0
oLed  out  10  status: [9:5] = oC zero-extended or truncated to 5 bits; [4:0] = one-hot state

Behaviour:
- Reset (not_reset=0 at a clock edge): state IDLE; oC=0, oInvert=0, oBoxStart=0, oThrStart=0, oDone=0, oError=0, oFrameCount=0, watchdog=0; oLed=10'b00000_00001.
- Reset applies mid-frame with no completion side effects.
- Reset is synchronous only; there is no asynchronous path.
- State encoding: IDLE=0, BOX=1, THR=2, DONE=3, ERROR=4. One-hot LED bits: IDLE 00001, BOX 00010, THR 00100, DONE 01000, ERROR 10000.
- IDLE:
  - iStart=1 → next cycle: state=BOX, oBoxStart=1 for exactly that cycle, oC<=iC, oInvert<=iInvert, watchdog cleared.
  - iAbort is ignored in IDLE.
- BOX:
  - Watchdog increments each cycle.
  - iBoxFinished=1 → next cycle: state=THR, oThrStart=1 for that cycle, watchdog cleared.
- THR:
  - Watchdog increments each cycle.
  - iThrFinished=1 → next cycle: state=DONE, oDone=1 for that cycle, oFrameCount+1 modulo 2**FRAME_CNT_BITS.
- DONE lasts exactly one cycle, then:
  - iContinuous=1 and iAbort=0 → BOX, with the same latch and pulse as IDLE start.
  - Otherwise → IDLE.
- Abort:
  - iAbort=1 in BOX or THR → IDLE next cycle.
  - No oDone, no count change, oError unchanged.
  - Abort beats finished in the same cycle.
- Watchdog:
  - Watchdog reaching all ones in BOX or THR without finished → ERROR next cycle, oError=1.
  - Finished in the same cycle as watchdog all-ones: finished wins.
  - Abort beats the watchdog.
- ERROR: oError stays 1. iStart=1 → oError cleared, then the IDLE start sequence runs (directly to BOX).
- iStart while BOX, THR or DONE is ignored; there is no queuing.
- Finished inputs are only observed in their own state; stray assertion elsewhere is ignored.
- oBusy = (state==BOX || state==THR), combinational from the state register.
- Address mux is combinational with zero latency: oImageCol/Row = Thr address when state==THR, else Box address.
- oC and oInvert are stable from the cycle oBoxStart is high until the next frame start.

Decomposition:
- Package adaptive_threshold_pkg holds:
  - state enum (IDLE, BOX, THR, DONE, ERROR) and its 3-bit width
  - LED one-hot constants
  - default WIDTH_BITS, HEIGHT_BITS, C_BITS
- One natural sub-module, stage_watchdog: counter with clear, enable and terminal-count output, parametrised by TIMEOUT_BITS.
- FSM, latches, frame counter and address mux stay in the top module.

Test Plan:
- Normal frame: reset, iC=5'd12, iStart pulse, iBoxFinished 10 cycles after oBoxStart, iThrFinished 10 cycles after oThrStart → exactly one oBoxStart, one oThrStart, one oDone; oFrameCount=1; oC=12; oLed=10'b01100_01000 during DONE, then 01100_00001.
- Address mux: iBoxCol=8'h11, iThrCol=8'h22 → oImageCol=8'h11 in IDLE and BOX, 8'h22 in THR, 8'h11 again in DONE.
- Continuous: iContinuous=1 over 3 frames with iC changed between frames → 3 oDone pulses; each DONE is followed immediately by oBoxStart with the new C latched; oFrameCount=3; no IDLE cycle between frames.
- Abort: iAbort in THR asserted together with iThrFinished → IDLE next cycle; no oDone; oFrameCount unchanged.
- Watchdog: TIMEOUT_BITS=4, iBoxFinished never asserted → ERROR 16 cycles after BOX entry; oError=1 held through 20 idle cycles; iStart → oError=0 and oBoxStart pulse. Separately, finished arriving on the terminal-count cycle → THR, not ERROR.
- Reset mid-BOX and wrap: not_reset=0 during BOX → all outputs at reset values next edge. FRAME_CNT_BITS=2 over 4 frames → oFrameCount wraps to 0.
